// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, forwarding select and branch flush control for the pipelined MIPS core
//
// Purpose
//   Tracks register writes still in flight across PIPE_DEPTH post-decode stages
//   (0=EX, 1=MEM, 2=WB, ...). From that record it:
//     - stalls/bubbles ID on a load-use hazard,
//     - registers the EX operand forwarding selects,
//     - flushes younger instructions on a taken branch/jump.
//
// Optional feature
//   HAZARD_PERF_EN: when defined, adds saturating stall and flush event counters.
//   Otherwise stall_cnt_o and flush_cnt_o are tied to zero.
//
// Parameters
//   PIPE_DEPTH      post-ID stages tracked, >= 2
//   LOAD_FWD_STAGE  lowest stage whose output carries load data, 1..PIPE_DEPTH-1
//   BRANCH_STAGE    stage in which branch_taken_i is resolved, 0..PIPE_DEPTH-2
//   SEL_W           forwarding select width (derived)
//
// Ports
//   clk_i, arst_ni            clock, asynchronous active-low reset
//   enable_i                  core enable; 0 freezes all state
//   id_valid_i                ID holds a real instruction
//   id_rs_i, id_rt_i          ID source registers
//   id_uses_rs_i/rt_i         source operand actually read
//   id_reg_write_i            ID instruction writes a register
//   id_mem_read_i             ID instruction is a load
//   id_waddr_i                ID destination register
//   branch_taken_i            redirect from stage BRANCH_STAGE
//   stall_o, bubble_o         hold PC/IF-ID, insert NOP into ID/EX
//   flush_o                   clear pipe registers upstream of BRANCH_STAGE+1
//   fwd_sel_a_o, fwd_sel_b_o  EX operand source: 0=regfile, k=stage k output
//   stall_cnt_o, flush_cnt_o  event counters
module hazard_unit #(
    parameter int PIPE_DEPTH     = 3,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int BRANCH_STAGE   = 1,
    localparam int SEL_W         = $clog2(PIPE_DEPTH)
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             enable_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic [4:0]       id_waddr_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic [SEL_W-1:0] fwd_sel_a_o,
    output logic [SEL_W-1:0] fwd_sel_b_o,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
);

    // One entry per post-ID stage; index 0 is the instruction currently in EX.
    logic [PIPE_DEPTH-1:0] ent_valid_q, ent_valid_d;
    logic [PIPE_DEPTH-1:0] ent_wr_q,    ent_wr_d;
    logic [PIPE_DEPTH-1:0] ent_load_q,  ent_load_d;
    logic [4:0]            ent_waddr_q [PIPE_DEPTH];
    logic [4:0]            ent_waddr_d [PIPE_DEPTH];

    logic [SEL_W-1:0]      sel_a_q, sel_a_d;
    logic [SEL_W-1:0]      sel_b_q, sel_b_d;

    logic [PIPE_DEPTH-1:0] match_rs;
    logic [PIPE_DEPTH-1:0] match_rt;
    logic                  load_use;
    logic [SEL_W-1:0]      cand_a;
    logic [SEL_W-1:0]      cand_b;

    // Producer matching; r0 and unused operands never match.
    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int j = 0; j < PIPE_DEPTH; j++) begin
            match_rs[j] = ent_valid_q[j] & ent_wr_q[j] & (ent_waddr_q[j] == id_rs_i)
                          & (id_rs_i != 5'd0) & id_uses_rs_i;
            match_rt[j] = ent_valid_q[j] & ent_wr_q[j] & (ent_waddr_q[j] == id_rt_i)
                          & (id_rt_i != 5'd0) & id_uses_rt_i;
        end
    end

    // A load at entry j reaches stage j+1 when the consumer is in EX; if that stage
    // is still upstream of where load data appears, the consumer must wait.
    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < PIPE_DEPTH; j++) begin
            if ((match_rs[j] | match_rt[j]) & ent_load_q[j] & (j + 1 < LOAD_FWD_STAGE)) begin
                load_use = 1'b1;
            end
        end
    end

    assign flush_o  = branch_taken_i & enable_i;
    assign stall_o  = load_use & id_valid_i & ~flush_o;
    assign bubble_o = stall_o;

    // Youngest producer wins: scan oldest to youngest so the lowest j is written last.
    // The last stage is excluded because the regfile writes through on same-cycle reads.
    always_comb begin
        cand_a = '0;
        cand_b = '0;
        for (int j = PIPE_DEPTH - 2; j >= 0; j--) begin
            if (match_rs[j]) begin
                cand_a = SEL_W'(j + 1);
            end
            if (match_rt[j]) begin
                cand_b = SEL_W'(j + 1);
            end
        end
    end

    always_comb begin
        sel_a_d = cand_a;
        sel_b_d = cand_b;
        if (!id_valid_i || stall_o || flush_o) begin
            sel_a_d = '0;
            sel_b_d = '0;
        end
    end

    // Shift the tracker; a flush kills everything younger than the branch stage.
    always_comb begin
        ent_valid_d    = '0;
        ent_wr_d       = '0;
        ent_load_d     = '0;
        for (int j = 0; j < PIPE_DEPTH; j++) begin
            ent_waddr_d[j] = 5'd0;
        end
        ent_valid_d[0]    = id_valid_i & ~stall_o & ~flush_o;
        ent_wr_d[0]       = id_reg_write_i;
        ent_load_d[0]     = id_mem_read_i;
        ent_waddr_d[0]    = id_waddr_i;
        for (int j = 1; j < PIPE_DEPTH; j++) begin
            ent_valid_d[j] = ent_valid_q[j-1] & ~(flush_o & (j - 1 < BRANCH_STAGE));
            ent_wr_d[j]    = ent_wr_q[j-1];
            ent_load_d[j]  = ent_load_q[j-1];
            ent_waddr_d[j] = ent_waddr_q[j-1];
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ent_valid_q <= '0;
            ent_wr_q    <= '0;
            ent_load_q  <= '0;
            for (int j = 0; j < PIPE_DEPTH; j++) begin
                ent_waddr_q[j] <= 5'd0;
            end
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else if (enable_i) begin
            ent_valid_q <= ent_valid_d;
            ent_wr_q    <= ent_wr_d;
            ent_load_q  <= ent_load_d;
            for (int j = 0; j < PIPE_DEPTH; j++) begin
                ent_waddr_q[j] <= ent_waddr_d[j];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_sel_a_o = sel_a_q;
    assign fwd_sel_b_o = sel_b_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_o && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (enable_i) begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       enable;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic       branch_taken;

    logic        stall, bubble, flush;
    logic [1:0]  sel_a, sel_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic        stall4, bubble4, flush4;
    logic [1:0]  sel_a4, sel_b4;
    logic [31:0] stall_cnt4, flush_cnt4;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt, wr, ld;
        logic [4:0] wa;
        logic       br;
        logic       xs, xf;
        logic [1:0] xa, xb;
    } stim_t;

    logic [3:0] sel_q [$];

    always #5 clk = ~clk;

    hazard_unit u_dut (
        .clk_i(clk), .arst_ni(arst_n), .enable_i(enable), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_waddr_i(id_waddr),
        .branch_taken_i(branch_taken), .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .fwd_sel_a_o(sel_a), .fwd_sel_b_o(sel_b), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_unit #(.PIPE_DEPTH(4), .LOAD_FWD_STAGE(3), .BRANCH_STAGE(1)) u_dut4 (
        .clk_i(clk), .arst_ni(arst_n), .enable_i(enable), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_waddr_i(id_waddr),
        .branch_taken_i(branch_taken), .stall_o(stall4), .bubble_o(bubble4), .flush_o(flush4),
        .fwd_sel_a_o(sel_a4), .fwd_sel_b_o(sel_b4), .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    function automatic stim_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                 logic wr, logic ld, logic [4:0] wa, logic br,
                                 logic xs, logic xf, logic [1:0] xa, logic [1:0] xb);
        stim_t s;
        s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.wr = wr; s.ld = ld;
        s.wa = wa; s.br = br; s.xs = xs; s.xf = xf; s.xa = xa; s.xb = xb;
        return s;
    endfunction

    function automatic stim_t idle_s();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(stim_t s);
        id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
        id_reg_write = s.wr; id_mem_read = s.ld; id_waddr = s.wa; branch_taken = s.br;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(idle_s());
        end
        sel_q.delete();
    endtask

    task automatic test_reset();
        arst_n = 1'b0; enable = 1'b1; drive(idle_s());
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({stall, bubble, flush, sel_a, sel_b} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 0", {stall, bubble, flush, sel_a, sel_b});
        end
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 32'd0 || flush_cnt4 !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        n_cmp++;
        if ({stall4, bubble4, flush4, sel_a4, sel_b4} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs4: got %b expected 0", {stall4, bubble4, flush4, sel_a4, sel_b4});
        end
        @(negedge clk); arst_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t t[$];
        logic [3:0] e;
        idle(3);
        t.push_back(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));  // lw  $2,0($1)
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 1, 0, 0, 0));  // add $3,$2,$4 stalls
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 2, 0));  // retried add
        t.push_back(idle_s());
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            n_cmp++;
            if (stall !== t[i].xs || bubble !== t[i].xs) begin
                n_fail++; $display("FAIL load_use_stall[%0d]: stall=%b bubble=%b expected %b", i, stall, bubble, t[i].xs);
            end
            n_cmp++;
            if (flush !== t[i].xf) begin
                n_fail++; $display("FAIL load_use_flush[%0d]: got %b expected %b", i, flush, t[i].xf);
            end
            if (sel_q.size() > 0) begin
                e = sel_q.pop_front();
                n_cmp++;
                if ({sel_a, sel_b} !== e) begin
                    n_fail++; $display("FAIL load_use_sel[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i, sel_a, sel_b, e[3:2], e[1:0]);
                end
            end
            sel_q.push_back((t[i].xs || t[i].xf || !t[i].v) ? 4'd0 : {t[i].xa, t[i].xb});
        end
    endtask

    task automatic test_forward();
        stim_t t[$];
        logic [3:0] e;
        idle(3);
        t.push_back(mk(1, 1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0));    // add $5,$1,$1
        t.push_back(mk(1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 0, 1, 1));    // sub $6,$5,$5
        t.push_back(mk(1, 5, 6, 1, 1, 1, 0, 11, 0, 0, 0, 2, 1));   // and $11,$5,$6
        t.push_back(mk(1, 1, 1, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0));    // add $7
        t.push_back(mk(1, 1, 1, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0));    // add $7 again
        t.push_back(mk(1, 7, 0, 1, 1, 1, 0, 13, 0, 0, 0, 1, 0));   // reads $7, $0
        t.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));    // lw $0
        t.push_back(mk(1, 0, 0, 1, 1, 1, 0, 14, 0, 0, 0, 0, 0));   // reads $0,$0
        t.push_back(mk(1, 1, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 0));    // lw $9
        t.push_back(mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));    // jump, operands unused
        t.push_back(mk(1, 1, 1, 1, 1, 1, 0, 12, 0, 0, 0, 0, 0));   // add $12
        t.push_back(idle_s());
        t.push_back(idle_s());
        t.push_back(mk(1, 12, 12, 1, 1, 1, 0, 15, 0, 0, 0, 0, 0)); // $12 producer in last stage
        t.push_back(idle_s());
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            n_cmp++;
            if (stall !== t[i].xs || bubble !== t[i].xs) begin
                n_fail++; $display("FAIL forward_stall[%0d]: stall=%b bubble=%b expected %b", i, stall, bubble, t[i].xs);
            end
            if (sel_q.size() > 0) begin
                e = sel_q.pop_front();
                n_cmp++;
                if ({sel_a, sel_b} !== e) begin
                    n_fail++; $display("FAIL forward_sel[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i, sel_a, sel_b, e[3:2], e[1:0]);
                end
            end
            sel_q.push_back((t[i].xs || t[i].xf || !t[i].v) ? 4'd0 : {t[i].xa, t[i].xb});
        end
    endtask

    task automatic test_branch();
        stim_t t[$];
        logic [3:0] e;
        idle(3);
        t.push_back(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));  // lw $2
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 1, 0, 1, 0, 0));  // load-use + branch: flush wins
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));  // killed lw no longer hazards
        t.push_back(idle_s());
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            n_cmp++;
            if (stall !== t[i].xs || bubble !== t[i].xs) begin
                n_fail++; $display("FAIL branch_stall[%0d]: stall=%b bubble=%b expected %b", i, stall, bubble, t[i].xs);
            end
            n_cmp++;
            if (flush !== t[i].xf) begin
                n_fail++; $display("FAIL branch_flush[%0d]: got %b expected %b", i, flush, t[i].xf);
            end
            if (sel_q.size() > 0) begin
                e = sel_q.pop_front();
                n_cmp++;
                if ({sel_a, sel_b} !== e) begin
                    n_fail++; $display("FAIL branch_sel[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i, sel_a, sel_b, e[3:2], e[1:0]);
                end
            end
            sel_q.push_back((t[i].xs || t[i].xf || !t[i].v) ? 4'd0 : {t[i].xa, t[i].xb});
        end
    endtask

    task automatic test_deep();
        stim_t t[$];
        logic [3:0] e;
        idle(4);
        t.push_back(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));  // lw $2
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 1, 0, 0, 0));  // stall 1
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 1, 0, 0, 0));  // stall 2
        t.push_back(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 3, 0));  // proceeds
        t.push_back(idle_s());
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            n_cmp++;
            if (stall4 !== t[i].xs || bubble4 !== t[i].xs) begin
                n_fail++; $display("FAIL deep_stall[%0d]: stall=%b bubble=%b expected %b", i, stall4, bubble4, t[i].xs);
            end
            if (sel_q.size() > 0) begin
                e = sel_q.pop_front();
                n_cmp++;
                if ({sel_a4, sel_b4} !== e) begin
                    n_fail++; $display("FAIL deep_sel[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i, sel_a4, sel_b4, e[3:2], e[1:0]);
                end
            end
            sel_q.push_back((t[i].xs || t[i].xf || !t[i].v) ? 4'd0 : {t[i].xa, t[i].xb});
        end
    endtask

    task automatic test_enable();
        idle(3);
        @(negedge clk); drive(mk(1, 1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0));  // add $5
        @(negedge clk); drive(mk(1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 0, 0, 0));  // sub $6,$5,$5
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); enable = 1'b0; drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); #1;
            n_cmp++;
            if (flush !== 1'b0) begin
                n_fail++; $display("FAIL enable_flush[%0d]: got %b expected 0", i, flush);
            end
            n_cmp++;
            if (sel_a !== 2'd1 || sel_b !== 2'd1) begin
                n_fail++; $display("FAIL enable_hold_sel[%0d]: got a=%0d b=%0d expected a=1 b=1", i, sel_a, sel_b);
            end
        end
        @(negedge clk); enable = 1'b1; drive(mk(1, 6, 5, 1, 1, 1, 0, 8, 0, 0, 0, 0, 0));
        @(negedge clk); drive(idle_s()); #1;
        n_cmp++;
        if (sel_a !== 2'd1 || sel_b !== 2'd2) begin
            n_fail++; $display("FAIL enable_frozen_tracker: got a=%0d b=%0d expected a=1 b=2", sel_a, sel_b);
        end
    endtask

    task automatic test_perf_counters();
        logic [31:0] exp_s, exp_f;
        idle(3);
        @(negedge clk); drive(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        @(negedge clk); drive(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0)); #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_pre: stall=%b expected 1", stall);
        end
        #2 arst_n = 1'b0; #1;
        n_cmp++;
        if ({stall, bubble, flush, sel_a, sel_b} !== 7'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: outputs=%b cnt=%0d/%0d expected all 0", {stall, bubble, flush, sel_a, sel_b}, stall_cnt, flush_cnt);
        end
        @(negedge clk); arst_n = 1'b1; drive(idle_s());
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); drive(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));
            @(negedge clk); drive(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));
            @(negedge clk);
            @(negedge clk); drive(idle_s());
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        @(negedge clk); drive(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        @(negedge clk); enable = 1'b0; drive(mk(1, 2, 4, 1, 1, 1, 0, 3, 1, 0, 0, 0, 0)); #1;
        n_cmp++;
        if (stall !== 1'b1 || flush !== 1'b0) begin
            n_fail++; $display("FAIL perf_disabled_outputs: stall=%b flush=%b expected 1/0", stall, flush);
        end
        repeat (2) @(negedge clk);
`ifdef HAZARD_PERF_EN
        exp_s = 32'd3; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        n_cmp++;
        if (stall_cnt !== exp_s || flush_cnt !== exp_f) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_s, exp_f);
        end
        enable = 1'b1; drive(idle_s());
        #2 arst_n = 1'b0; #1;
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk); arst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_enable();
        test_deep();
        test_perf_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
